// File: rtl/user_cells_pkg.sv
// Shared constants and helpers for the user_rv_sync_multi synchroniser cells.
package user_cells_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Width of a counter able to hold 0..n, never narrower than one bit.
    function automatic int unsigned filt_cnt_w(input int n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/user_rv_sync_multi_if.sv
// Level-signal bundle between an asynchronous source (master) and the synchroniser (slave).
interface user_rv_sync_multi_if #(
    parameter int unsigned WIDTH = 1
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             chg;

    modport master (
        output d,
        input  q,
        input  rise,
        input  fall,
        input  chg
    );

    modport slave (
        input  d,
        output q,
        output rise,
        output fall,
        output chg
    );

endinterface

// File: rtl/user_sync_filter.sv
// One channel of the glitch filter: stability counter plus q/rise/fall registers.
module user_sync_filter
    import user_cells_pkg::*;
#(
    parameter int unsigned FILT_CYC = 4,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_in,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW       = filt_cnt_w(FILT_CYC);
    localparam logic [CW-1:0]   CNT_LAST = (FILT_CYC == 0) ? '0 : CW'(FILT_CYC - 1);
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    logic [CW-1:0] cnt_r;
    logic          differ_c;
    logic          take_c;

    // q adopts the input on the edge where the mismatch has lasted FILT_CYC cycles
    assign differ_c = s_in ^ q;
    assign take_c   = differ_c & (cnt_r == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
            q     <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= take_c & s_in;
            fall <= take_c & ~s_in;
            if (take_c) begin
                q     <= s_in;
                cnt_r <= '0;
            end else if (!differ_c) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/user_rv_sync_multi.sv
// Multi-channel level synchroniser with registered rise/fall pulses and change flag.
// Optional per-channel glitch filter enabled by defining USER_SYNC_FILTER_EN.
module user_rv_sync_multi
    import user_cells_pkg::*;
#(
    parameter int unsigned      WIDTH    = 1,
    parameter int unsigned      STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int unsigned      FILT_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    user_rv_sync_multi_if.slave bus
);

`ifdef USER_SYNC_FILTER_EN
    localparam bit FILT_BUILD = 1'b1;
`else
    localparam bit FILT_BUILD = 1'b0;
`endif

    localparam bit FILT_ON = FILT_BUILD && (FILT_CYC != 0);

    // Unfiltered, q itself is the last sync stage; filtered, q sits after a full chain.
    localparam int unsigned CHAIN_LEN = FILT_ON ? STAGES : STAGES - 1;

    if ((STAGES < SYNC_STAGES_MIN) || (STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
        $error("user_rv_sync_multi: STAGES must be within 2..4");
    end

    logic [WIDTH-1:0] sync_r [CHAIN_LEN];
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;

    for (genvar k = 0; k < CHAIN_LEN; k++) begin : g_stage
        if (k == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!rst_n) sync_r[k] <= RST_VAL;
                else        sync_r[k] <= bus.d;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (!rst_n) sync_r[k] <= RST_VAL;
                else        sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign s_in = sync_r[CHAIN_LEN-1];

    if (FILT_ON) begin : g_filt
`ifdef USER_SYNC_FILTER_EN
        for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
            user_sync_filter #(
                .FILT_CYC (FILT_CYC),
                .RST_VAL  (RST_VAL[ch])
            ) u_filt (
                .clk   (clk),
                .rst_n (rst_n),
                .s_in  (s_in[ch]),
                .q     (q_r[ch]),
                .rise  (rise_r[ch]),
                .fall  (fall_r[ch])
            );
        end
`endif
    end else begin : g_direct
        // Edge pulses are computed from the value entering q so they align with q
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_r    <= RST_VAL;
                rise_r <= '0;
                fall_r <= '0;
            end else begin
                q_r    <= s_in;
                rise_r <= s_in & ~q_r;
                fall_r <= ~s_in & q_r;
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;
    assign bus.chg  = |(rise_r | fall_r);

endmodule

// File: tb/tb_user_rv_sync_multi.sv
// Bench for user_rv_sync_multi: vector table, corner-case sequences and random stream vs window model.
module tb_user_rv_sync_multi;

`ifdef USER_SYNC_FILTER_EN
    localparam bit FILT_BUILD = 1'b1;
`else
    localparam bit FILT_BUILD = 1'b0;
`endif

    localparam logic [3:0] RSTV = 4'b1010;
    localparam int NDUT = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;

    int n_checks;
    int n_fail;

    user_rv_sync_multi_if #(.WIDTH(4)) bus0();
    user_rv_sync_multi_if #(.WIDTH(4)) bus1();
    user_rv_sync_multi_if #(.WIDTH(4)) bus2();
    user_rv_sync_multi_if #(.WIDTH(4)) bus3();

    user_rv_sync_multi #(.WIDTH(4), .STAGES(2), .RST_VAL(RSTV), .FILT_CYC(4))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    user_rv_sync_multi #(.WIDTH(4), .STAGES(3), .RST_VAL(RSTV), .FILT_CYC(4))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    user_rv_sync_multi #(.WIDTH(4), .STAGES(4), .RST_VAL(RSTV), .FILT_CYC(4))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    user_rv_sync_multi #(.WIDTH(4), .STAGES(3), .RST_VAL(RSTV), .FILT_CYC(0))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign bus0.d = d;
    assign bus1.d = d;
    assign bus2.d = d;
    assign bus3.d = d;

    logic [3:0] q_o    [NDUT];
    logic [3:0] rise_o [NDUT];
    logic [3:0] fall_o [NDUT];
    logic       chg_o  [NDUT];

    assign q_o[0] = bus0.q;  assign rise_o[0] = bus0.rise;  assign fall_o[0] = bus0.fall;  assign chg_o[0] = bus0.chg;
    assign q_o[1] = bus1.q;  assign rise_o[1] = bus1.rise;  assign fall_o[1] = bus1.fall;  assign chg_o[1] = bus1.chg;
    assign q_o[2] = bus2.q;  assign rise_o[2] = bus2.rise;  assign fall_o[2] = bus2.fall;  assign chg_o[2] = bus2.chg;
    assign q_o[3] = bus3.q;  assign rise_o[3] = bus3.rise;  assign fall_o[3] = bus3.fall;  assign chg_o[3] = bus3.chg;

    // Per-instance configuration seen by the model (filter window is 0 when not built)
    int stg_t [NDUT];
    int flt_t [NDUT];

    // Model: history of sampled inputs and of the filter input, window-based filter rule
    logic [3:0] hist  [NDUT][8];
    logic [3:0] fhist [NDUT][8];
    logic [3:0] qm    [NDUT];
    logic [3:0] rm    [NDUT];
    logic [3:0] fm    [NDUT];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_update();
        logic [3:0] v;
        logic [3:0] mis;
        logic [3:0] qn;
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) begin
                    hist[i][k]  = RSTV;
                    fhist[i][k] = RSTV;
                end
                qm[i] = RSTV;
                rm[i] = 4'b0000;
                fm[i] = 4'b0000;
            end else begin
                v = hist[i][stg_t[i]-1];
                for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = d;
                if (flt_t[i] == 0) begin
                    qn = hist[i][stg_t[i]-1];
                end else begin
                    for (int k = 7; k > 0; k--) fhist[i][k] = fhist[i][k-1];
                    fhist[i][0] = v;
                    mis = 4'b1111;
                    for (int k = 0; k < flt_t[i]; k++) mis = mis & (fhist[i][k] ^ qm[i]);
                    qn = (qm[i] & ~mis) | (v & mis);
                end
                rm[i] = qn & ~qm[i];
                fm[i] = ~qn & qm[i];
                qm[i] = qn;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("dut%0d q", i),    32'(q_o[i]),    32'(qm[i]));
            check($sformatf("dut%0d rise", i), 32'(rise_o[i]), 32'(rm[i]));
            check($sformatf("dut%0d fall", i), 32'(fall_o[i]), 32'(fm[i]));
            check($sformatf("dut%0d chg", i),  32'(chg_o[i]),  32'(|(rm[i] | fm[i])));
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, sample next fall
    task automatic step(input logic r, input logic [3:0] dv);
        rst_n = r;
        d     = dv;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic settle();
        step(1'b0, 4'b0000);
        for (int j = 0; j < 14; j++) step(1'b1, 4'b0000);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } vec_t;

    vec_t vt [22];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int         lat   [NDUT];
        bit         seen  [NDUT];
        int         pulses;
        int         qlat;
        logic       r;
        logic [3:0] dv;

        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        d        = 4'b0000;
        stg_t    = '{2, 3, 4, 3};
        flt_t    = FILT_BUILD ? '{4, 4, 4, 0} : '{0, 0, 0, 0};

        // Table for the unfiltered STAGES=3 instance: reset, release, simultaneous edges, reset mid-flight
        vt[0]  = '{1'b0, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        vt[1]  = '{1'b0, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        vt[2]  = '{1'b0, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        vt[3]  = '{1'b1, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        vt[4]  = '{1'b1, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        vt[5]  = '{1'b1, 4'b0101, 4'b0101, 4'b0101, 4'b1010, 1'b1};
        vt[6]  = '{1'b1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
        vt[7]  = '{1'b1, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0};
        vt[8]  = '{1'b1, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0};
        vt[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b1};
        vt[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[11] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[12] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[13] = '{1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1};
        vt[14] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1};
        vt[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[16] = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[17] = '{1'b0, 4'b0100, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        vt[18] = '{1'b1, 4'b0100, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        vt[19] = '{1'b1, 4'b0100, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        vt[20] = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b1010, 1'b1};
        vt[21] = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0};

        @(negedge clk);
        for (int v = 0; v < 22; v++) begin
            step(vt[v].rst, vt[v].d);
            check($sformatf("vec%0d q", v),    32'(q_o[3]),    32'(vt[v].q));
            check($sformatf("vec%0d rise", v), 32'(rise_o[3]), 32'(vt[v].rise));
            check($sformatf("vec%0d fall", v), 32'(fall_o[3]), 32'(vt[v].fall));
            check($sformatf("vec%0d chg", v),  32'(chg_o[3]),  32'(vt[v].chg));
        end

        // Latency sweep on channel 0 for every instance
        settle();
        for (int i = 0; i < NDUT; i++) begin
            lat[i]  = 0;
            seen[i] = 1'b0;
        end
        for (int j = 1; j <= 20; j++) begin
            step(1'b1, 4'b0001);
            for (int i = 0; i < NDUT; i++) begin
                if (!seen[i] && q_o[i][0]) begin
                    seen[i] = 1'b1;
                    lat[i]  = j;
                    check($sformatf("lat dut%0d rise0", i), 32'(rise_o[i][0]), 32'd1);
                    check($sformatf("lat dut%0d chg", i),   32'(chg_o[i]),     32'd1);
                end else if (seen[i] && (j == lat[i] + 1)) begin
                    check($sformatf("lat dut%0d rise0 end", i), 32'(rise_o[i][0]), 32'd0);
                    check($sformatf("lat dut%0d chg end", i),   32'(chg_o[i]),     32'd0);
                end
            end
        end
        for (int i = 0; i < NDUT; i++)
            check($sformatf("lat dut%0d cycles", i), 32'(lat[i]), 32'(stg_t[i] + flt_t[i]));

        // Short glitch on channel 1: swallowed by the filter, passed through otherwise
        settle();
        pulses = 0;
        for (int j = 0; j < 15; j++) begin
            step(1'b1, (j < 3) ? 4'b0010 : 4'b0000);
            pulses += int'(rise_o[0][1]);
        end
        check("glitch rise1 count", 32'(pulses), FILT_BUILD ? 32'd0 : 32'd1);

        // Eight-cycle high on channel 1 passes with STAGES+FILT_CYC latency
        settle();
        pulses = 0;
        qlat   = 0;
        for (int j = 1; j <= 20; j++) begin
            step(1'b1, (j <= 8) ? 4'b0010 : 4'b0000);
            pulses += int'(rise_o[0][1]);
            if (qlat == 0 && q_o[0][1]) qlat = j;
        end
        check("pulse8 q1 latency", 32'(qlat), FILT_BUILD ? 32'd6 : 32'd2);
        check("pulse8 rise1 count", 32'(pulses), 32'd1);

        // Random stream with occasional resets against the model
        settle();
        dv = 4'b0000;
        for (int j = 0; j < 1000; j++) begin
            r = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(2) == 0) dv = dv ^ 4'($urandom_range(15));
            step(r, dv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
